// File: rtl/vis_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vis_ctrl_pkg
// Purpose  : Shared types and constants for the visualization mode control
//            path: scheduler state encoding, mode/fade types and the
//            level-to-gain mapping used by the fade sequencer.
// Contents : vis_state_t, mode_t, fade_t, VIS_NUM_MODES, VIS_MODE_W,
//            fade_gain()
// Revision : 1.0 - initial release
// ============================================================================
package vis_ctrl_pkg;

  localparam int VIS_NUM_MODES = 9;
  localparam int VIS_MODE_W    = 4;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } vis_state_t;

  typedef logic [VIS_MODE_W-1:0] mode_t;
  typedef logic [7:0]            fade_t;

  // Fade level (0..2^log2) to 8-bit gain. The top level maps to full scale
  // (255) so a settled mode is shown unattenuated; lower levels are a plain
  // left shift, which keeps the ramp linear.
  function automatic fade_t fade_gain(input logic [8:0] lvl, input int log2);
    int l;
    l = int'(lvl);
    if (l == (1 << log2)) begin
      return 8'hFF;
    end
    return fade_t'(l << (8 - log2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Purpose  : Synchronizes an active-low push-button and emits a one-cycle
//            press pulse once the level has been low for DEBOUNCE_CYCLES
//            consecutive cycles. Re-arms only after an equally long high.
// Ports    : iCLK   - clock
//            iRST_N - asynchronous active-low reset
//            iKEY_N - raw button level, active-low, bouncy
//            oPRESS - registered one-cycle press pulse
// Revision : 1.0 - initial release
// ============================================================================
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iKEY_N,
  output logic oPRESS
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             r_keyMeta;
  logic             r_keySync;
  logic             r_stable;   // debounced level, 1 = released
  logic [CNT_W-1:0] r_cnt;      // consecutive cycles the level disagrees
  logic             r_press;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_keyMeta <= 1'b1;
      r_keySync <= 1'b1;
      r_stable  <= 1'b1;
      r_cnt     <= '0;
      r_press   <= 1'b0;
    end else begin
      r_keyMeta <= iKEY_N;
      r_keySync <= r_keyMeta;
      r_press   <= 1'b0;
      if (r_keySync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Level held for the full window: accept it. Only the falling
        // transition produces an event; the rising one just re-arms.
        r_stable <= r_keySync;
        r_cnt    <= '0;
        r_press  <= ~r_keySync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign oPRESS = r_press;

endmodule
`default_nettype wire

// File: rtl/vis_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vis_mode_scheduler
// Purpose  : Selects the active visualization mode and sequences every
//            change as fade-out, swap at frame boundary, fade-in, so the
//            VGA mux never switches mid-frame at full brightness.
// Ports    : iCLK_50     - 50 MHz clock
//            iRST_N      - asynchronous active-low reset
//            iVS         - VGA vsync (asynchronous, synchronized here)
//            iSW_MODE    - manual mode request
//            iSW_AUTO    - 1 = auto rotation, 0 = manual
//            iKEY_NEXT   - raw active-low "next" button
//            oMODE       - mode index to the VGA mux
//            oFADE       - video gain, 255 = full, 0 = black
//            oBUSY       - high while a fade is in progress
//            oFRAME_TICK - one-cycle pulse per frame
// Revision : 1.0 - initial release
// ============================================================================
module vis_mode_scheduler
  import vis_ctrl_pkg::*;
#(
  parameter int NUM_MODES       = VIS_NUM_MODES,
  parameter int MODE_W          = VIS_MODE_W,
  parameter int DWELL_FRAMES    = 256,
  parameter int FADE_LOG2       = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              iCLK_50,
  input  logic              iRST_N,
  input  logic              iVS,
  input  logic [MODE_W-1:0] iSW_MODE,
  input  logic              iSW_AUTO,
  input  logic              iKEY_NEXT,
  output logic [MODE_W-1:0] oMODE,
  output fade_t             oFADE,
  output logic              oBUSY,
  output logic              oFRAME_TICK
);

  localparam int         DWELL_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [8:0] LVL_FULL = 9'(1 << FADE_LOG2);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  // Frame tick from the asynchronous vsync
  logic r_vsMeta, r_vsSync, r_vsPrev, r_frameTick;
  logic w_tick;

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vsMeta    <= 1'b0;
      r_vsSync    <= 1'b0;
      r_vsPrev    <= 1'b0;
      r_frameTick <= 1'b0;
    end else begin
      r_vsMeta    <= iVS;
      r_vsSync    <= r_vsMeta;
      r_vsPrev    <= r_vsSync;
      r_frameTick <= w_tick;
    end
  end

  // All state updates are keyed to this so they land together with the
  // registered oFRAME_TICK pulse.
  assign w_tick = r_vsSync & ~r_vsPrev;

  // "Next" key
  logic w_keyPress;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_keyDebouncer (
    .iCLK  (iCLK_50),
    .iRST_N(iRST_N),
    .iKEY_N(iKEY_NEXT),
    .oPRESS(w_keyPress)
  );

  // Target mode resolution
  vis_state_t        r_state;
  logic [8:0]        r_lvl;
  logic [MODE_W-1:0] r_mode;
  fade_t             r_fade;
  logic              r_busy;

  logic [MODE_W-1:0] r_autoTarget;
  logic [DWELL_W-1:0] r_dwell;
  logic [MODE_W-1:0] w_swClamped;
  logic [MODE_W-1:0] w_autoNext;
  logic [MODE_W-1:0] w_target;
  logic              w_showTick;
  logic              w_dwellExp;

  assign w_swClamped = (int'(iSW_MODE) < NUM_MODES) ? iSW_MODE : MODE_LAST;
  assign w_autoNext  = (r_autoTarget == MODE_LAST) ? '0 : r_autoTarget + MODE_W'(1);
  assign w_target    = iSW_AUTO ? r_autoTarget : w_swClamped;
  assign w_showTick  = w_tick && (r_state == SHOW);
  assign w_dwellExp  = w_showTick && (r_dwell == DWELL_W'(DWELL_FRAMES - 1));

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_autoTarget <= '0;
      r_dwell      <= '0;
    end else if (!iSW_AUTO) begin
      // Shadow the displayed mode so entering auto starts from what is on
      // screen instead of jumping.
      r_autoTarget <= r_mode;
      r_dwell      <= '0;
    end else if (w_keyPress || w_dwellExp) begin
      // Coincident key and expiry collapse into a single step.
      r_autoTarget <= w_autoNext;
      r_dwell      <= '0;
    end else if (w_showTick) begin
      r_dwell <= r_dwell + DWELL_W'(1);
    end
  end

  // Fade sequencer
  logic [8:0] w_lvlDn, w_lvlUp;
  assign w_lvlDn = r_lvl - 9'd1;
  assign w_lvlUp = r_lvl + 9'd1;

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= SHOW;
      r_lvl   <= LVL_FULL;
      r_mode  <= '0;
      r_fade  <= 8'hFF;
      r_busy  <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        SHOW: begin
          if (w_target != r_mode) begin
            r_lvl  <= w_lvlDn;
            r_fade <= fade_gain(w_lvlDn, FADE_LOG2);
            r_busy <= 1'b1;
            // With a single-step fade the first decrement is already black.
            if (w_lvlDn == 9'd0) begin
              r_mode  <= w_target;
              r_state <= FADE_IN;
            end else begin
              r_state <= FADE_OUT;
            end
          end
        end
        FADE_OUT: begin
          r_lvl  <= w_lvlDn;
          r_fade <= fade_gain(w_lvlDn, FADE_LOG2);
          if (w_lvlDn == 9'd0) begin
            r_mode  <= w_target;
            r_state <= FADE_IN;
          end
        end
        FADE_IN: begin
          // Target changes here are deliberately not acted on until SHOW.
          r_lvl  <= w_lvlUp;
          r_fade <= fade_gain(w_lvlUp, FADE_LOG2);
          if (w_lvlUp == LVL_FULL) begin
            r_state <= SHOW;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= SHOW;
        end
      endcase
    end
  end

  assign oMODE       = r_mode;
  assign oFADE       = r_fade;
  assign oBUSY       = r_busy;
  assign oFRAME_TICK = r_frameTick;

endmodule
`default_nettype wire

// File: tb/tb_vis_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vis_mode_scheduler
// Purpose  : Directed self-checking bench for vis_mode_scheduler with short
//            debounce/dwell/fade settings and a 64-clock vsync period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vis_mode_scheduler;

  logic       iCLK_50 = 1'b0;
  logic       iRST_N;
  logic       iVS;
  logic [3:0] iSW_MODE;
  logic       iSW_AUTO;
  logic       iKEY_NEXT;
  logic [3:0] oMODE;
  logic [7:0] oFADE;
  logic       oBUSY;
  logic       oFRAME_TICK;

  always #5 iCLK_50 = ~iCLK_50;

  vis_mode_scheduler #(
    .NUM_MODES      (9),
    .MODE_W         (4),
    .DWELL_FRAMES   (4),
    .FADE_LOG2      (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .iCLK_50    (iCLK_50),
    .iRST_N     (iRST_N),
    .iVS        (iVS),
    .iSW_MODE   (iSW_MODE),
    .iSW_AUTO   (iSW_AUTO),
    .iKEY_NEXT  (iKEY_NEXT),
    .oMODE      (oMODE),
    .oFADE      (oFADE),
    .oBUSY      (oBUSY),
    .oFRAME_TICK(oFRAME_TICK)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         phase       = 40;   // position within the 64-clock frame
  int         keyLowLeft  = 0;    // cycles left to hold the key low
  logic [3:0] prevMode    = 4'd0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input int m, input int f, input int b);
    chk({tag, ".mode"}, int'(oMODE), m);
    chk({tag, ".fade"}, int'(oFADE), f);
    chk({tag, ".busy"}, int'(oBUSY), b);
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge.
  task automatic step();
    @(negedge iCLK_50);
    iVS = (phase < 32);
    if (keyLowLeft > 0) begin
      iKEY_NEXT = 1'b0;
      keyLowLeft--;
    end else begin
      iKEY_NEXT = 1'b1;
    end
    @(posedge iCLK_50);
    #1;
    if (oMODE !== prevMode) begin
      chk("mode_change_on_tick", int'(oFRAME_TICK), 1);
      prevMode = oMODE;
    end
    phase = (phase + 1) % 64;
  endtask

  task automatic waitPhase(input int p);
    while (phase != p) step();
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    step();
    while (oFRAME_TICK !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("tick_seen", int'(oFRAME_TICK), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int expF[8] = '{192, 128, 64, 0, 64, 128, 192, 255};
    int expB[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int expM[8] = '{0, 0, 0, 3, 3, 3, 3, 3};

    iRST_N = 1'b1; iVS = 1'b0; iSW_MODE = 4'd0; iSW_AUTO = 1'b0; iKEY_NEXT = 1'b1;
    #2 iRST_N = 1'b0;
    #1;
    chkOut("reset", 0, 255, 0);
    chk("reset.tick", int'(oFRAME_TICK), 0);
    prevMode = oMODE;
    repeat (3) step();
    iRST_N = 1'b1;

    // First vsync rise after release: tick appears on the third edge
    waitPhase(0);
    step(); chk("tick_lat0", int'(oFRAME_TICK), 0);
    step(); chk("tick_lat1", int'(oFRAME_TICK), 0);
    step(); chk("tick_lat2", int'(oFRAME_TICK), 1);

    // Manual change 0 -> 3
    iSW_MODE = 4'd3;
    for (int i = 0; i < 8; i++) begin
      waitTick();
      chkOut($sformatf("manual_t%0d", i + 1), expM[i], expF[i], expB[i]);
    end

    // Clamp: 15 -> 8
    iSW_MODE = 4'd15;
    repeat (4) waitTick();
    chkOut("clamp_t4", 8, 0, 1);
    repeat (4) waitTick();
    chkOut("clamp_t8", 8, 255, 0);

    // Auto rotation from 8 wraps to 0 after the dwell
    iSW_AUTO = 1'b1;
    repeat (4) waitTick();
    chkOut("auto_t4", 8, 255, 0);
    waitTick();
    chkOut("auto_t5", 8, 192, 1);
    repeat (3) waitTick();
    chkOut("auto_t8", 0, 0, 1);
    repeat (4) waitTick();
    chkOut("auto_t12", 0, 255, 0);

    // Key press timed to land on the dwell-expiry tick (T15)
    repeat (2) waitTick();
    waitPhase(60);
    keyLowLeft = 10;
    waitTick();
    chkOut("coincide_t15", 0, 255, 0);
    waitTick();
    chkOut("coincide_t16", 0, 192, 1);
    repeat (3) waitTick();
    chkOut("coincide_t19", 1, 0, 1);
    repeat (4) waitTick();
    chkOut("coincide_t23", 1, 255, 0);

    // Two 2-cycle glitches: no advance
    waitPhase(10);
    keyLowLeft = 2;
    waitPhase(30);
    keyLowLeft = 2;
    waitTick();
    chkOut("glitch_t24", 1, 255, 0);

    // 10-cycle press: exactly one advance
    waitPhase(10);
    keyLowLeft = 10;
    waitTick();
    chkOut("press_t25", 1, 192, 1);
    repeat (3) waitTick();
    chkOut("press_t28", 2, 0, 1);
    repeat (4) waitTick();
    chkOut("press_t32", 2, 255, 0);

    // Held low for 1000 cycles: one key advance, then only dwell rotation
    waitPhase(10);
    keyLowLeft = 1000;
    waitTick();
    chkOut("hold_t33", 2, 192, 1);
    repeat (3) waitTick();
    chkOut("hold_t36", 3, 0, 1);
    repeat (4) waitTick();
    chkOut("hold_t40", 3, 255, 0);
    waitTick();
    chkOut("hold_t41", 3, 255, 0);
    waitTick();
    chkOut("hold_t42", 3, 255, 0);
    waitTick();
    chkOut("hold_t43", 3, 255, 0);
    repeat (4) waitTick();
    chkOut("hold_t47", 4, 0, 1);

    // Back to manual mode 0 during fade-in: fade-in completes first
    iSW_AUTO = 1'b0;
    iSW_MODE = 4'd0;
    waitTick();
    chkOut("manual_fadein_t48", 4, 64, 1);
    repeat (3) waitTick();
    chkOut("manual_fadein_t51", 4, 255, 0);
    waitTick();
    chkOut("refade_t52", 4, 192, 1);
    waitTick();
    chkOut("refade_t53", 4, 128, 1);

    // Reset in the middle of FADE_OUT takes effect immediately
    iRST_N = 1'b0;
    #1;
    chkOut("midreset", 0, 255, 0);
    chk("midreset.tick", int'(oFRAME_TICK), 0);
    prevMode = oMODE;
    repeat (2) step();
    iRST_N = 1'b1;
    repeat (2) waitTick();
    chkOut("after_reset", 0, 255, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
